// File: rtl/core_pkg.sv
// core_pkg: shared sizing constants and physical register index type for the OoO backend
package core_pkg;
  localparam int NUM_PREGS = 64;
  localparam int REG_WIDTH = 32;
  localparam int DISPATCH_WIDTH = 2;
  localparam int NUM_WB = 3;
  localparam int PREG_W = $clog2(NUM_PREGS);
  typedef logic [PREG_W-1:0] preg_idx_t;
endpackage

// File: rtl/phys_regfile_if.sv
// phys_regfile_if: dispatch read/alloc lanes, writeback buses and flush into the physical register file
interface phys_regfile_if;
  import core_pkg::*;
  preg_idx_t rd_addr_rs1 [DISPATCH_WIDTH];
  preg_idx_t rd_addr_rs2 [DISPATCH_WIDTH];
  logic [REG_WIDTH-1:0] rd_data_rs1 [DISPATCH_WIDTH];
  logic [REG_WIDTH-1:0] rd_data_rs2 [DISPATCH_WIDTH];
  logic rdy_rs1 [DISPATCH_WIDTH];
  logic rdy_rs2 [DISPATCH_WIDTH];
  logic alloc_valid [DISPATCH_WIDTH];
  preg_idx_t alloc_preg [DISPATCH_WIDTH];
  logic wb_valid [NUM_WB];
  preg_idx_t wb_preg [NUM_WB];
  logic [REG_WIDTH-1:0] wb_data [NUM_WB];
  logic flush;
  modport master (
    output rd_addr_rs1, rd_addr_rs2, alloc_valid, alloc_preg, wb_valid, wb_preg, wb_data, flush,
    input rd_data_rs1, rd_data_rs2, rdy_rs1, rdy_rs2
  );
  modport slave (
    input rd_addr_rs1, rd_addr_rs2, alloc_valid, alloc_preg, wb_valid, wb_preg, wb_data, flush,
    output rd_data_rs1, rd_data_rs2, rdy_rs1, rdy_rs2
  );
endinterface

// File: rtl/phys_ready_table.sv
// phys_ready_table: per-preg ready bits, updated by alloc/wb/flush; REGFILE_BYPASS_EN forwards same-cycle wb readiness
module phys_ready_table import core_pkg::*; (
  input  logic      clk,
  input  logic      rst,
  input  logic      alloc_valid [DISPATCH_WIDTH],
  input  preg_idx_t alloc_preg [DISPATCH_WIDTH],
  input  logic      wb_valid [NUM_WB],
  input  preg_idx_t wb_preg [NUM_WB],
  input  logic      flush,
  input  preg_idx_t rd_addr_rs1 [DISPATCH_WIDTH],
  input  preg_idx_t rd_addr_rs2 [DISPATCH_WIDTH],
  output logic      rdy_rs1 [DISPATCH_WIDTH],
  output logic      rdy_rs2 [DISPATCH_WIDTH]
);
  logic [NUM_PREGS-1:0] ready;
  // alloc is applied after wb so it wins; flush overrides alloc; preg 0 is never cleared
  always_ff @(posedge clk) begin
    if (rst) begin
      ready <= '1;
    end else begin
      for (int w = 0; w < NUM_WB; w++)
        if (wb_valid[w]) ready[wb_preg[w]] <= 1'b1;
      if (flush) ready <= '1;
      else
        for (int l = 0; l < DISPATCH_WIDTH; l++)
          if (alloc_valid[l] && alloc_preg[l] != '0) ready[alloc_preg[l]] <= 1'b0;
    end
  end
  always_comb begin
    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      rdy_rs1[l] = ready[rd_addr_rs1[l]];
      rdy_rs2[l] = ready[rd_addr_rs2[l]];
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NUM_WB; w++) begin
        rdy_rs1[l] = rdy_rs1[l] | (wb_valid[w] && wb_preg[w] != '0 && wb_preg[w] == rd_addr_rs1[l]);
        rdy_rs2[l] = rdy_rs2[l] | (wb_valid[w] && wb_preg[w] != '0 && wb_preg[w] == rd_addr_rs2[l]);
      end
`endif
    end
  end
endmodule

// File: rtl/phys_regfile.sv
// phys_regfile: multi-ported physical register file with ready bits; REGFILE_BYPASS_EN enables wb->read forwarding
module phys_regfile import core_pkg::*; (
  input logic clk,
  input logic rst,
  phys_regfile_if.slave bus
);
  logic [REG_WIDTH-1:0] mem [NUM_PREGS];
  phys_ready_table u_ready (
    .clk         (clk),
    .rst         (rst),
    .alloc_valid (bus.alloc_valid),
    .alloc_preg  (bus.alloc_preg),
    .wb_valid    (bus.wb_valid),
    .wb_preg     (bus.wb_preg),
    .flush       (bus.flush),
    .rd_addr_rs1 (bus.rd_addr_rs1),
    .rd_addr_rs2 (bus.rd_addr_rs2),
    .rdy_rs1     (bus.rdy_rs1),
    .rdy_rs2     (bus.rdy_rs2)
  );
  // entry 0 is never written, so it reads back as zero without a separate mux
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PREGS; i++) mem[i] <= '0;
    end else begin
      for (int w = 0; w < NUM_WB; w++)
        if (bus.wb_valid[w] && bus.wb_preg[w] != '0) mem[bus.wb_preg[w]] <= bus.wb_data[w];
    end
  end
  always_comb begin
    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      bus.rd_data_rs1[l] = mem[bus.rd_addr_rs1[l]];
      bus.rd_data_rs2[l] = mem[bus.rd_addr_rs2[l]];
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NUM_WB; w++) begin
        if (bus.wb_valid[w] && bus.wb_preg[w] != '0 && bus.wb_preg[w] == bus.rd_addr_rs1[l])
          bus.rd_data_rs1[l] = bus.wb_data[w];
        if (bus.wb_valid[w] && bus.wb_preg[w] != '0 && bus.wb_preg[w] == bus.rd_addr_rs2[l])
          bus.rd_data_rs2[l] = bus.wb_data[w];
      end
`endif
    end
  end
endmodule
